// File: rtl/arb_mux_pkg.sv
// Shared types and constants for the arbitrated channel mux.
package arb_mux_pkg;

  // Arbitration policy selector.
  typedef enum logic [0:0] {
    ARB_RR    = 1'b0,
    ARB_FIXED = 1'b1
  } arb_mode_t;

  localparam int unsigned MinChannels = 2;
  localparam int unsigned MaxChannels = 16;

  // True when c is a legal channel count (power of two within range).
  function automatic logic chan_count_ok(input int unsigned c);
    return (c >= MinChannels) && (c <= MaxChannels) && ((c & (c - 1)) == 0);
  endfunction

endpackage

// File: rtl/arb_mux_rr_arbiter.sv
// Combinational arbiter: picks one requesting channel, searching from a start
// pointer (round-robin) or from channel 0 (fixed priority).
module rr_arbiter
  import arb_mux_pkg::*;
#(
  parameter int unsigned C    = 4,
  parameter arb_mode_t   MODE = ARB_RR,
  localparam int unsigned CW  = $clog2(C)
) (
  input  logic [C-1:0]  req_i,
  input  logic [CW-1:0] ptr_i,
  output logic [C-1:0]  gnt_o,
  output logic [CW-1:0] idx_o,
  output logic          any_o
);

  logic [CW-1:0] start;
  logic [CW-1:0] chan;

  // Walk channels start, start+1, ... modulo C; first requester wins.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    chan  = '0;
    start = (MODE == ARB_FIXED) ? '0 : ptr_i;
    for (int unsigned k = 0; k < C; k++) begin
      // CW-bit add wraps naturally because C is a power of two.
      chan = start + CW'(k);
      if (!any_o && req_i[chan]) begin
        any_o       = 1'b1;
        gnt_o[chan] = 1'b1;
        idx_o       = chan;
      end
    end
  end

endmodule

// File: rtl/arb_mux.sv
// C-to-1 arbitrated mux with a single registered output stage and
// valid/ready handshakes on both sides.
module arb_mux
  import arb_mux_pkg::*;
#(
  parameter int unsigned N    = 64,
  parameter int unsigned C    = 4,
  parameter arb_mode_t   MODE = ARB_RR,
  localparam int unsigned CW  = $clog2(C)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic [C-1:0]  i_valid,
  input  logic [N-1:0]  i_data [C],
  output logic [C-1:0]  o_ready,
  output logic          o_valid,
  output logic [N-1:0]  o_data,
  output logic [CW-1:0] o_chan,
  input  logic          i_ready
);

  logic          valid_q, valid_d;
  logic [N-1:0]  data_q, data_d;
  logic [CW-1:0] chan_q, chan_d;
  logic [CW-1:0] ptr_q, ptr_d;

  logic [C-1:0]  gnt;
  logic [CW-1:0] gnt_idx;
  logic          gnt_any;
  logic          free;
  logic          in_xfer;

  rr_arbiter #(
    .C    (C),
    .MODE (MODE)
  ) u_arb (
    .req_i (i_valid),
    .ptr_i (ptr_q),
    .gnt_o (gnt),
    .idx_o (gnt_idx),
    .any_o (gnt_any)
  );

  // Accept a new beat when the output register is empty or draining this cycle.
  // Reset gates o_ready because valid_q = 0 would otherwise look "free".
  always_comb begin
    free    = !valid_q || i_ready;
    in_xfer = free && gnt_any && i_rst_n;
    o_ready = in_xfer ? gnt : '0;
  end

  // Next-state for the output stage and the round-robin pointer.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    chan_d  = chan_q;
    ptr_d   = ptr_q;
    if (in_xfer) begin
      valid_d = 1'b1;
      data_d  = i_data[gnt_idx];
      chan_d  = gnt_idx;
      if (MODE == ARB_RR) begin
        ptr_d = gnt_idx + CW'(1);
      end
    end else if (free) begin
      valid_d = 1'b0;
    end
  end

  // State registers; reset drops any held beat and restarts search at 0.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      chan_q  <= '0;
      ptr_q   <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      chan_q  <= chan_d;
      ptr_q   <= ptr_d;
    end
  end

  assign o_valid = valid_q;
  assign o_data  = data_q;
  assign o_chan  = chan_q;

endmodule

// File: tb/tb_arb_mux.sv
// Directed bench for arb_mux: round-robin and fixed-priority 4x64 instances on
// shared stimulus, plus a 16x8 round-robin instance for the wide sweep.
module tb_arb_mux;
  import arb_mux_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [3:0]  valid;
  logic [63:0] din [4];
  logic        ready;

  logic [3:0]  rr_oready, fx_oready;
  logic        rr_ovalid, fx_ovalid;
  logic [63:0] rr_odata, fx_odata;
  logic [1:0]  rr_ochan, fx_ochan;

  logic [15:0] w_valid;
  logic [7:0]  w_din [16];
  logic        w_ready;
  logic [15:0] w_oready;
  logic        w_ovalid;
  logic [7:0]  w_odata;
  logic [3:0]  w_ochan;

  logic [63:0] dval [4];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  arb_mux #(.N(64), .C(4), .MODE(ARB_RR)) dut_rr (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_valid (valid),
    .i_data  (din),
    .o_ready (rr_oready),
    .o_valid (rr_ovalid),
    .o_data  (rr_odata),
    .o_chan  (rr_ochan),
    .i_ready (ready)
  );

  arb_mux #(.N(64), .C(4), .MODE(ARB_FIXED)) dut_fx (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_valid (valid),
    .i_data  (din),
    .o_ready (fx_oready),
    .o_valid (fx_ovalid),
    .o_data  (fx_odata),
    .o_chan  (fx_ochan),
    .i_ready (ready)
  );

  arb_mux #(.N(8), .C(16), .MODE(ARB_RR)) dut_w (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_valid (w_valid),
    .i_data  (w_din),
    .o_ready (w_oready),
    .o_valid (w_ovalid),
    .o_data  (w_odata),
    .o_chan  (w_ochan),
    .i_ready (w_ready)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    dval[0] = 64'h0123_4567_89AB_CDEF;
    dval[1] = 64'hFEDC_BA98_7654_3210;
    dval[2] = 64'h0000_0000_0000_00A5;
    dval[3] = 64'h8000_0000_0000_0001;
    for (int k = 0; k < 4; k++) din[k] = dval[k];
    for (int k = 0; k < 16; k++) w_din[k] = 8'(8'h11 * k);
    valid   = 4'b1111;
    ready   = 1'b1;
    w_valid = '0;
    w_ready = 1'b1;

    // Reset: requests present but nothing may be accepted.
    #1 rst_n = 1'b0;
    #1;
    chk("rst_ovalid", 64'(rr_ovalid), 64'd0);
    chk("rst_odata", rr_odata, 64'd0);
    chk("rst_ochan", 64'(rr_ochan), 64'd0);
    chk("rst_oready", 64'(rr_oready), 64'd0);
    tick();
    tick();
    rst_n = 1'b1;
    valid = 4'b0000;
    #1;

    // Single request from channel 2.
    valid = 4'b0100;
    #1 chk("single_oready", 64'(rr_oready), 64'b0100);
    tick();
    valid = 4'b0000;
    #1;
    chk("single_ovalid", 64'(rr_ovalid), 64'd1);
    chk("single_odata", rr_odata, 64'hA5);
    chk("single_ochan", 64'(rr_ochan), 64'd2);
    chk("idle_oready", 64'(rr_oready), 64'd0);
    tick();
    chk("drain_ovalid", 64'(rr_ovalid), 64'd0);
    chk("drain_chan_hold", 64'(rr_ochan), 64'd2);

    // Pointer is 3: only channel 1 requests, search wraps 3,0,1.
    valid = 4'b0010;
    #1 chk("wrap_oready", 64'(rr_oready), 64'b0010);
    tick();
    valid = 4'b1111;
    #1;
    chk("wrap_ochan", 64'(rr_ochan), 64'd1);
    chk("wrap_ptr2_oready", 64'(rr_oready), 64'b0100);
    tick();
    chk("pre_rst_ochan", 64'(rr_ochan), 64'd2);

    // Asynchronous reset in mid-traffic, checked without any clock edge.
    rst_n = 1'b0;
    #1;
    chk("async_ovalid", 64'(rr_ovalid), 64'd0);
    chk("async_odata", rr_odata, 64'd0);
    chk("async_ochan", 64'(rr_ochan), 64'd0);
    chk("async_oready", 64'(rr_oready), 64'd0);
    rst_n = 1'b1;
    #1;

    // Round-robin with all channels requesting: 0,1,2,3,0,1,2,3.
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("rr_oready_%0d", i), 64'(rr_oready), 64'(1 << (i % 4)));
      tick();
      chk($sformatf("rr_ovalid_%0d", i), 64'(rr_ovalid), 64'd1);
      chk($sformatf("rr_ochan_%0d", i), 64'(rr_ochan), 64'(i % 4));
      chk($sformatf("rr_odata_%0d", i), rr_odata, dval[i % 4]);
    end

    // Back-pressure: beat from channel 3 held for 5 cycles.
    ready = 1'b0;
    #1 chk("bp_oready", 64'(rr_oready), 64'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("bp_ovalid_%0d", i), 64'(rr_ovalid), 64'd1);
      chk($sformatf("bp_ochan_%0d", i), 64'(rr_ochan), 64'd3);
      chk($sformatf("bp_odata_%0d", i), rr_odata, dval[3]);
      chk($sformatf("bp_oready_%0d", i), 64'(rr_oready), 64'd0);
    end
    ready = 1'b1;
    #1 chk("bp_release_oready", 64'(rr_oready), 64'b0001);
    tick();
    chk("refill_ovalid", 64'(rr_ovalid), 64'd1);
    chk("refill_ochan", 64'(rr_ochan), 64'd0);

    // Requests on 1 and 3: fixed always picks 1, round-robin alternates.
    valid = 4'b1010;
    #1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("fx_oready_%0d", i), 64'(fx_oready), 64'b0010);
      chk($sformatf("rr13_oready_%0d", i), 64'(rr_oready), (i % 2 == 1) ? 64'b1000 : 64'b0010);
      tick();
      chk($sformatf("fx_ochan_%0d", i), 64'(fx_ochan), 64'd1);
      chk($sformatf("fx_odata_%0d", i), fx_odata, dval[1]);
      chk($sformatf("rr13_ochan_%0d", i), 64'(rr_ochan), (i % 2 == 1) ? 64'd3 : 64'd1);
    end
    valid = 4'b0000;

    // 16-channel, 8-bit sweep: full rotation then wrap/skip.
    w_valid = 16'hFFFF;
    #1;
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("w_oready_%0d", i), 64'(w_oready), 64'(1 << i));
      tick();
      chk($sformatf("w_ochan_%0d", i), 64'(w_ochan), 64'(i));
      chk($sformatf("w_odata_%0d", i), 64'(w_odata), 64'(8'h11 * i));
    end
    w_valid = 16'h4000;
    #1 chk("w_c14_oready", 64'(w_oready), 64'h4000);
    tick();
    w_valid = 16'h2002;
    #1;
    chk("w_c14_ochan", 64'(w_ochan), 64'd14);
    chk("w_wrap_oready", 64'(w_oready), 64'h0002);
    tick();
    w_valid = 16'h000A;
    #1;
    chk("w_wrap_ochan", 64'(w_ochan), 64'd1);
    chk("w_wrap_odata", 64'(w_odata), 64'h11);
    chk("w_ptr2_oready", 64'(w_oready), 64'h0008);
    tick();
    chk("w_ptr2_ochan", 64'(w_ochan), 64'd3);
    w_valid = '0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/arb_mux.md
ARB_MUX -- requirements
Module: arb_mux

Interface
REQ-001 Parameter N, default 64, data width per channel in bits (N >= 1).
REQ-002 Parameter C, default 4, channel count; SHALL be a power of two, 2..16.
REQ-003 Parameter MODE, default ARB_RR, arbitration mode of type arb_mode_t (ARB_RR round-robin, ARB_FIXED fixed priority, lowest index wins).
REQ-004 Localparam CW = $clog2(C), channel-index width.
REQ-005 i_clk  in  1  single clock, all state on rising edge.
REQ-006 i_rst_n  in  1  asynchronous active-low reset.
REQ-007 i_valid  in  C  per-channel request; bit k qualifies i_data[k].
REQ-008 i_data  in  C x N  per-channel payload, unpacked array indexed 0..C-1.
REQ-009 o_ready  out  C  per-channel accept; one-hot or zero.
REQ-010 o_valid  out  1  output register holds a beat.
REQ-011 o_data  out  N  registered payload of the granted channel.
REQ-012 o_chan  out  CW  index of the channel that supplied o_data.
REQ-013 i_ready  in  1  downstream accept of the current output beat.

Function
REQ-014 Handshake: input beat k transfers when i_valid[k] && o_ready[k]; output beat transfers when o_valid && i_ready.
REQ-015 Output register is "free" when !o_valid || i_ready (same-cycle drain and refill allowed).
REQ-016 When free and at least one i_valid bit set, exactly one o_ready bit SHALL assert, chosen by the arbiter; otherwise o_ready = 0.
REQ-017 o_ready SHALL be combinational from i_valid, o_valid, i_ready and the priority pointer; no path from i_data.
REQ-018 On an input transfer from channel g: o_data <= i_data[g], o_chan <= g, o_valid <= 1 at the next rising edge (latency 1 cycle).
REQ-019 On output transfer with no input transfer, o_valid <= 0; o_data/o_chan hold their values.
REQ-020 While o_valid && !i_ready, o_valid, o_data, o_chan SHALL be stable.
REQ-021 ARB_RR: pointer p (CW bits) gives search start; grant = first valid channel in order p, p+1, ..., wrapping modulo C.
REQ-022 ARB_RR: after each input transfer from g, p <= (g + 1) mod C; wrap from C-1 to 0; p unchanged when no transfer.
REQ-023 ARB_FIXED: grant = lowest-index valid channel; pointer unused and held at 0.
REQ-024 Full throughput: with i_ready held 1 and requests present, one beat per cycle.
REQ-025 Fairness (ARB_RR): with all C channels continuously valid and i_ready = 1, each channel granted exactly once per C consecutive beats.
REQ-026 A channel dropping i_valid without a transfer SHALL lose no state; no grant is latched across cycles.

Reset
REQ-027 Asynchronous assertion of i_rst_n = 0 SHALL immediately force o_valid = 0, o_data = 0, o_chan = 0, p = 0; o_ready = 0 while in reset.
REQ-028 Reset mid-beat discards the held beat; first post-reset grant starts search at channel 0.
REQ-029 Deassertion is taken synchronous to i_clk; first transfer possible on the first edge after release.

Structure
REQ-030 Package arb_mux_pkg SHALL hold typedef enum arb_mode_t {ARB_RR, ARB_FIXED} and shared constants.
REQ-031 Arbitration SHALL live in sub-module rr_arbiter (params C, MODE; in: request vector, pointer; out: one-hot grant, grant index); arb_mux holds the register stage and pointer.
REQ-032 Data selection uses the grant index into i_data; no C x N wide priority chains.

Verification
REQ-033 Reset: drive i_rst_n = 0 mid-traffic -> o_valid, o_data, o_chan, o_ready all 0 within the same cycle, no clock needed.
REQ-034 Single request: C=4, i_valid = 0100, i_data[2] = 64'hA5, i_ready = 1 -> o_ready = 0100, next cycle o_valid = 1, o_data = 64'hA5, o_chan = 2.
REQ-035 Round-robin: C=4, ARB_RR, i_valid = 1111 for 8 cycles, i_ready = 1 -> o_chan sequence 0,1,2,3,0,1,2,3, one beat per cycle.
REQ-036 Back-pressure: o_valid = 1, i_ready = 0 for 5 cycles with i_valid = 1111 -> o_ready = 0000, o_data/o_chan stable; on i_ready = 1, drain and refill in the same cycle.
REQ-037 Fixed priority: MODE = ARB_FIXED, i_valid = 1010 continuously, i_ready = 1 -> o_chan = 1 every beat, channel 3 starved.
REQ-038 Wrap/skip: ARB_RR, p = 3, i_valid = 0010 -> grant channel 1, then p = 2; with N = 8, C = 16 a parameter sweep shows identical behaviour.
